// File: rtl/sb_mem_slave.sv
// sb_mem_slave: word-addressed RAM target on the shared system bus.
// Decodes its own window on a begin cycle, returns read bursts after a
// programmable first-word latency, accepts byte-enabled write bursts and
// signals misaligned accesses with an error pulse followed by an end pulse.
// Every output is forced to zero when not driving so slaves can be OR-ed.
// Optional feature macro: SB_MEM_BUSY_INJECT_EN (one busy cycle after each
// accepted write beat; when undefined busy is tied low).
module sb_mem_slave #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          ADDR_WIDTH   = 10,
  parameter int          READ_LATENCY = 2
) (
  input  logic        sb_clock_i,
  input  logic        sb_reset_i,
  input  logic        sb_begin_transaction_i,
  input  logic [31:0] sb_address_data_i,
  input  logic [7:0]  sb_burst_size_i,
  input  logic        sb_read_n_write_i,
  input  logic [3:0]  sb_byte_enables_i,
  input  logic        sb_data_valid_i,
  input  logic        sb_end_transaction_i,
  input  logic        sb_error_i,
  output logic [31:0] sb_address_data_o,
  output logic        sb_data_valid_o,
  output logic        sb_end_transaction_o,
  output logic        sb_busy_o,
  output logic        sb_error_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LATENCY  = 3'd1;
  localparam logic [2:0] S_READ     = 3'd2;
  localparam logic [2:0] S_READ_END = 3'd3;
  localparam logic [2:0] S_WRITE    = 3'd4;
  localparam logic [2:0] S_ERR      = 3'd5;
  localparam logic [2:0] S_ERR_END  = 3'd6;

  localparam logic [3:0]            LAT_INIT = 4'(READ_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);

  logic [2:0]            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] index_reg, index_next;
  logic [ADDR_WIDTH-1:0] rd_index, begin_index;
  logic [8:0]            count_reg, count_next;
  logic [3:0]            lat_reg, lat_next;
  logic [3:0]            be_reg, be_next;
  logic                  rd_en, wr_en, busy_reg;
  logic                  window_hit, abort;
  logic                  data_valid_reg, end_reg, error_reg;
  logic [31:0]           rd_data;

  assign window_hit  = (sb_address_data_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign begin_index = sb_address_data_i[ADDR_WIDTH+1:2];
  assign abort       = sb_end_transaction_i | sb_error_i;

  // A write beat lands only while the burst still has room and we are not throttling.
  assign wr_en = (state_reg == S_WRITE) && sb_data_valid_i && !busy_reg &&
                 (count_reg != 9'd0) && !sb_error_i;

`ifdef SB_MEM_BUSY_INJECT_EN
  // Throttle for exactly one cycle after every accepted beat.
  always_ff @(posedge sb_clock_i or negedge sb_reset_i) begin
    if (!sb_reset_i) busy_reg <= 1'b0;
    else             busy_reg <= wr_en;
  end
`else
  assign busy_reg = 1'b0;
`endif

  // Next-state logic: window decode, latency countdown, beat issue and aborts.
  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    count_next = count_reg;
    lat_next   = lat_reg;
    be_next    = be_reg;
    rd_en      = 1'b0;
    rd_index   = index_reg;
    case (state_reg)
      S_IDLE: begin
        if (sb_begin_transaction_i && window_hit) begin
          be_next    = sb_byte_enables_i;
          index_next = begin_index;
          count_next = {1'b0, sb_burst_size_i} + 9'd1;
          if (sb_address_data_i[1:0] != 2'b00) begin
            state_next = S_ERR;
          end else if (!sb_read_n_write_i) begin
            state_next = S_WRITE;
          end else if (READ_LATENCY == 1) begin
            // No latency stage: the first RAM read is issued in the begin cycle.
            state_next = S_READ;
            rd_en      = 1'b1;
            rd_index   = begin_index;
            index_next = begin_index + IDX_ONE;
            count_next = {1'b0, sb_burst_size_i};
          end else begin
            state_next = S_LATENCY;
            lat_next   = LAT_INIT;
          end
        end
      end
      S_LATENCY: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (lat_reg == 4'd1) begin
          state_next = S_READ;
          rd_en      = 1'b1;
          index_next = index_reg + IDX_ONE;
          count_next = count_reg - 9'd1;
        end else begin
          lat_next = lat_reg - 4'd1;
        end
      end
      S_READ: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (count_reg != 9'd0) begin
          rd_en      = 1'b1;
          index_next = index_reg + IDX_ONE;
          count_next = count_reg - 9'd1;
        end else begin
          state_next = S_READ_END;
        end
      end
      S_WRITE: begin
        if (wr_en) begin
          index_next = index_reg + IDX_ONE;
          count_next = count_reg - 9'd1;
        end
        if (abort) state_next = S_IDLE;
      end
      S_ERR:      state_next = abort ? S_IDLE : S_ERR_END;
      S_READ_END: state_next = S_IDLE;
      S_ERR_END:  state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // State and output registers; outputs follow the state being entered.
  always_ff @(posedge sb_clock_i or negedge sb_reset_i) begin
    if (!sb_reset_i) begin
      state_reg      <= S_IDLE;
      index_reg      <= '0;
      count_reg      <= 9'd0;
      lat_reg        <= 4'd0;
      be_reg         <= 4'd0;
      data_valid_reg <= 1'b0;
      end_reg        <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      index_reg      <= index_next;
      count_reg      <= count_next;
      lat_reg        <= lat_next;
      be_reg         <= be_next;
      data_valid_reg <= (state_next == S_READ);
      end_reg        <= (state_next == S_READ_END) || (state_next == S_ERR_END);
      error_reg      <= (state_next == S_ERR);
    end
  end

  // One byte-wide RAM per lane so byte enables map onto plain lane writes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_q;

      // Lane write on accepted beats, registered read when a beat is issued.
      always_ff @(posedge sb_clock_i) begin
        if (wr_en && be_reg[gi]) lane_mem[index_reg] <= sb_address_data_i[8*gi +: 8];
        if (rd_en)               lane_q <= lane_mem[rd_index];
      end

      assign rd_data[8*gi +: 8] = lane_q;
    end
  endgenerate

  assign sb_address_data_o    = data_valid_reg ? rd_data : 32'h0;
  assign sb_data_valid_o      = data_valid_reg;
  assign sb_end_transaction_o = end_reg;
  assign sb_error_o           = error_reg;
  assign sb_busy_o            = busy_reg;

endmodule
